// File: rtl/modk_pkg.sv
`default_nettype none
// ============================================================================
// Package   : modk_pkg
// Purpose   : Shared definitions for the programmable modulo counter:
//             FSM state encoding, count direction constants and the
//             smallest legal modulus.
// Revision  : 1.0  initial release
// ============================================================================
package modk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } modk_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int MOD_MIN = 2;

endpackage : modk_pkg
`default_nettype wire

// File: rtl/modk_modulus_reg.sv
`default_nettype none
// ============================================================================
// Module    : modk_modulus_reg
// Purpose   : Modulus shadow register. A legal write (ModIn >= 2) lands in
//             the shadow and raises Pending; the active modulus M takes the
//             shadow value on a cycle where the parent opens the commit
//             window (Commit=1) while a write is pending.
// Ports     : Clk, Reset (async, high)
//             ModWr/ModIn  - shadow write strobe and value
//             Commit       - commit window from the counter FSM
//             M            - active modulus
//             Shadow       - shadow value (used for commit-time clamping)
//             Pending      - shadow holds an uncommitted value
// Revision  : 1.0  initial release
// ============================================================================
module modk_modulus_reg
   import modk_pkg::*;
#(
   parameter int N         = 5,
   parameter int K_DEFAULT = 20
)
(
   input  logic         Clk,
   input  logic         Reset,
   input  logic         ModWr,
   input  logic [N-1:0] ModIn,
   input  logic         Commit,
   output logic [N-1:0] M,
   output logic [N-1:0] Shadow,
   output logic         Pending
);

   logic [N-1:0] r_m;
   logic [N-1:0] r_shadow;
   logic         r_pending;
   logic         w_wr_ok;
   logic         w_commit;

   assign w_wr_ok  = ModWr && (ModIn >= N'(MOD_MIN));
   assign w_commit = Commit && r_pending;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_m       <= N'(K_DEFAULT);
         r_shadow  <= N'(K_DEFAULT);
         r_pending <= 1'b0;
      end else begin
         if (w_commit)
            r_m <= r_shadow;
         // A write coinciding with a commit keeps pending set so the new
         // value is committed at the following opportunity.
         if (w_wr_ok) begin
            r_shadow  <= ModIn;
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign M       = r_m;
   assign Shadow  = r_shadow;
   assign Pending = r_pending;

endmodule : modk_modulus_reg
`default_nettype wire

// File: rtl/prog_modulo_counter.sv
`default_nettype none
// ============================================================================
// Module    : prog_modulo_counter
// Purpose   : Up/down modulo-M counter with run-time programmable modulus,
//             synchronous saturating load and a one-shot/continuous FSM.
// Ports     : Clk, Reset (async, high)
//             En, Up, Load, LoadVal, ModWr, ModIn, OneShot, Start - controls
//             Q (count), Rollover (wrap pulse), Busy (RUN), Done (one-shot)
// Options   : MODK_CASCADE_EN adds CarryIn/CarryOut for zero-lag chaining;
//             the effective enable becomes En & CarryIn.
// Revision  : 1.0  initial release
// ============================================================================
module prog_modulo_counter
   import modk_pkg::*;
#(
   parameter int N         = 5,
   parameter int K_DEFAULT = 20
)
(
   input  logic         Clk,
   input  logic         Reset,
   input  logic         En,
   input  logic         Up,
   input  logic         Load,
   input  logic [N-1:0] LoadVal,
   input  logic         ModWr,
   input  logic [N-1:0] ModIn,
   input  logic         OneShot,
   input  logic         Start,
   output logic [N-1:0] Q,
   output logic         Rollover,
   output logic         Busy,
   output logic         Done
`ifdef MODK_CASCADE_EN
   ,
   input  logic         CarryIn,
   output logic         CarryOut
`endif
);

   localparam logic [N-1:0] c_one  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] c_zero = '0;

   modk_state_t  r_state, w_state_nxt;
   logic [N-1:0] r_q, w_q_nxt;
   logic         r_roll;
   logic         r_done, w_done_nxt;

   logic [N-1:0] w_m;
   logic [N-1:0] w_shadow;
   logic         w_pending;
   logic [N-1:0] w_m_eff;
   logic         w_en_eff;
   logic         w_busy;
   logic         w_terminal;
   logic         w_step;
   logic         w_wrap;
   logic         w_commit_win;
   logic         w_commit;

`ifdef MODK_CASCADE_EN
   assign w_en_eff = En & CarryIn;
`else
   assign w_en_eff = En;
`endif

   assign w_busy       = (r_state == RUN);
   assign w_terminal   = (Up == DIR_UP) ? (r_q == w_m - c_one) : (r_q == c_zero);
   assign w_step       = w_busy && w_en_eff && !Load;
   assign w_wrap       = w_step && w_terminal;
   // While running, a pending modulus is only taken at a wrap edge so a
   // period is never cut short; outside RUN it is taken immediately.
   assign w_commit_win = !w_busy || w_wrap;
   assign w_commit     = w_commit_win && w_pending;
   assign w_m_eff      = w_commit ? w_shadow : w_m;

   modk_modulus_reg #(
      .N         (N),
      .K_DEFAULT (K_DEFAULT)
   ) u_modulus (
      .Clk     (Clk),
      .Reset   (Reset),
      .ModWr   (ModWr),
      .ModIn   (ModIn),
      .Commit  (w_commit_win),
      .M       (w_m),
      .Shadow  (w_shadow),
      .Pending (w_pending)
   );

   // Next count value
   always_comb begin
      w_q_nxt = r_q;
      if (Load) begin
         w_q_nxt = (LoadVal >= w_m_eff) ? (w_m_eff - c_one) : LoadVal;
      end else if (w_step) begin
         if (Up == DIR_UP)
            w_q_nxt = w_terminal ? c_zero : (r_q + c_one);
         else
            // A down-wrap that commits a new modulus restarts from the new
            // top so Q stays inside the new range.
            w_q_nxt = w_terminal ? (w_m_eff - c_one) : (r_q - c_one);
      end else if (w_commit && !w_busy && (r_q >= w_shadow)) begin
         w_q_nxt = c_zero;
      end
   end

   // FSM next state and Done flag
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = r_done;
      case (r_state)
         IDLE: begin
            if (Start || !OneShot)
               w_state_nxt = RUN;
         end
         RUN: begin
            if (w_wrap && OneShot) begin
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
            end
         end
         DONE: begin
            if (Load) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b0;
            end else if (Start) begin
               w_state_nxt = RUN;
               w_done_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_q     <= c_zero;
         r_roll  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_roll  <= w_wrap;
         r_done  <= w_done_nxt;
      end
   end

   assign Q        = r_q;
   assign Rollover = r_roll;
   assign Busy     = w_busy;
   assign Done     = r_done;

`ifdef MODK_CASCADE_EN
   assign CarryOut = w_busy && En && CarryIn && w_terminal;
`endif

endmodule : prog_modulo_counter
`default_nettype wire

// File: tb/tb_prog_modulo_counter.sv
`default_nettype none
// ============================================================================
// Module    : tb_prog_modulo_counter
// Purpose   : Directed self-checking bench for prog_modulo_counter
//             (N=5, K_DEFAULT=20). Observed tuple is {Q, Rollover, Busy, Done}.
//             With MODK_CASCADE_EN two extra M=4 stages are chained.
// Revision  : 1.0  initial release
// ============================================================================
module tb_prog_modulo_counter;

   localparam int N = 5;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         En, Up, Load, ModWr, OneShot, Start;
   logic [N-1:0] LoadVal, ModIn;
   logic [N-1:0] Q;
   logic         Rollover, Busy, Done;

   int nchecks = 0;
   int nerrors = 0;

   logic [N+2:0] obs, exp_v;

   always #5 Clk = ~Clk;

   assign obs = {Q, Rollover, Busy, Done};

`ifdef MODK_CASCADE_EN
   logic         CarryOut;
   logic [N-1:0] q1, q2;
   logic         r1, r2, b1, b2, d1, d2, co1, co2;

   prog_modulo_counter #(.N(N), .K_DEFAULT(4)) u_stage1 (
      .Clk(Clk), .Reset(Reset), .En(1'b1), .Up(1'b1), .Load(1'b0),
      .LoadVal({N{1'b0}}), .ModWr(1'b0), .ModIn({N{1'b0}}), .OneShot(1'b0),
      .Start(1'b0), .Q(q1), .Rollover(r1), .Busy(b1), .Done(d1),
      .CarryIn(1'b1), .CarryOut(co1)
   );

   prog_modulo_counter #(.N(N), .K_DEFAULT(4)) u_stage2 (
      .Clk(Clk), .Reset(Reset), .En(1'b1), .Up(1'b1), .Load(1'b0),
      .LoadVal({N{1'b0}}), .ModWr(1'b0), .ModIn({N{1'b0}}), .OneShot(1'b0),
      .Start(1'b0), .Q(q2), .Rollover(r2), .Busy(b2), .Done(d2),
      .CarryIn(co1), .CarryOut(co2)
   );
`endif

   prog_modulo_counter #(.N(N), .K_DEFAULT(20)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .En       (En),
      .Up       (Up),
      .Load     (Load),
      .LoadVal  (LoadVal),
      .ModWr    (ModWr),
      .ModIn    (ModIn),
      .OneShot  (OneShot),
      .Start    (Start),
      .Q        (Q),
      .Rollover (Rollover),
      .Busy     (Busy),
      .Done     (Done)
`ifdef MODK_CASCADE_EN
      ,
      .CarryIn  (1'b1),
      .CarryOut (CarryOut)
`endif
   );

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic apply_reset(input logic oneshot);
      Reset   = 1'b1;
      En      = 1'b1;
      Up      = 1'b1;
      Load    = 1'b0;
      LoadVal = '0;
      ModWr   = 1'b0;
      ModIn   = '0;
      OneShot = oneshot;
      Start   = 1'b0;
      tick;
      tick;
      Reset = 1'b0;
   endtask

   task automatic test_reset;
      apply_reset(1'b0);
      Reset = 1'b1;
      tick;
      exp_v = {5'd0, 1'b0, 1'b0, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL reset_hold: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
      Reset = 1'b0;
   endtask

   task automatic test_continuous_up;
      apply_reset(1'b0);
      for (int c = 1; c <= 25; c++) begin
         tick;
         exp_v = {N'((c - 1) % 20), (c == 21), 1'b1, 1'b0};
         nchecks++;
         if (obs !== exp_v) begin
            nerrors++;
            $display("FAIL up_c%0d: got {Q,R,B,D}=%b want %b", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_count_down;
      logic [N+2:0] tbl [4];
      tbl[0] = {5'd0,  1'b0, 1'b1, 1'b0};
      tbl[1] = {5'd19, 1'b1, 1'b1, 1'b0};
      tbl[2] = {5'd18, 1'b0, 1'b1, 1'b0};
      tbl[3] = {5'd17, 1'b0, 1'b1, 1'b0};
      Load    = 1'b1;
      LoadVal = 5'd0;
      for (int i = 0; i < 4; i++) begin
         tick;
         Load = 1'b0;
         Up   = 1'b0;
         nchecks++;
         if (obs !== tbl[i]) begin
            nerrors++;
            $display("FAIL down_%0d: got {Q,R,B,D}=%b want %b", i, obs, tbl[i]);
         end
      end
      Up = 1'b1;
   endtask

   task automatic test_modwr;
      Load    = 1'b1;
      LoadVal = 5'd5;
      tick;
      Load  = 1'b0;
      ModWr = 1'b1;
      ModIn = 5'd8;
      tick;
      ModWr = 1'b0;
      exp_v = {5'd6, 1'b0, 1'b1, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL modwr_first: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
      // Old modulus still governs this period: 7..19 then wrap.
      for (int v = 7; v <= 20; v++) begin
         tick;
         exp_v = {N'(v % 20), (v == 20), 1'b1, 1'b0};
         nchecks++;
         if (obs !== exp_v) begin
            nerrors++;
            $display("FAIL modwr_old_%0d: got {Q,R,B,D}=%b want %b", v, obs, exp_v);
         end
      end
      // New modulus 8: 1..7 then wrap.
      for (int v = 1; v <= 8; v++) begin
         if (v == 1) begin
            ModWr = 1'b1;
            ModIn = 5'd1;
         end
         tick;
         ModWr = 1'b0;
         exp_v = {N'(v % 8), (v == 8), 1'b1, 1'b0};
         nchecks++;
         if (obs !== exp_v) begin
            nerrors++;
            $display("FAIL modwr_new_%0d: got {Q,R,B,D}=%b want %b", v, obs, exp_v);
         end
      end
      // The illegal ModIn=1 must leave M at 8.
      for (int v = 1; v <= 8; v++) begin
         tick;
         exp_v = {N'(v % 8), (v == 8), 1'b1, 1'b0};
         nchecks++;
         if (obs !== exp_v) begin
            nerrors++;
            $display("FAIL modwr_ign_%0d: got {Q,R,B,D}=%b want %b", v, obs, exp_v);
         end
      end
   endtask

   task automatic test_oneshot;
      apply_reset(1'b1);
      tick;
      exp_v = {5'd0, 1'b0, 1'b0, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL os_idle: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
      Start = 1'b1;
      tick;
      Start = 1'b0;
      exp_v = {5'd0, 1'b0, 1'b1, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL os_start: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
      for (int v = 1; v <= 21; v++) begin
         tick;
         if (v <= 19)      exp_v = {N'(v), 1'b0, 1'b1, 1'b0};
         else if (v == 20) exp_v = {5'd0, 1'b1, 1'b0, 1'b1};
         else              exp_v = {5'd0, 1'b0, 1'b0, 1'b1};
         nchecks++;
         if (obs !== exp_v) begin
            nerrors++;
            $display("FAIL os_run_%0d: got {Q,R,B,D}=%b want %b", v, obs, exp_v);
         end
      end
      Start = 1'b1;
      tick;
      Start = 1'b0;
      exp_v = {5'd0, 1'b0, 1'b1, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL os_restart: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
      tick;
      exp_v = {5'd1, 1'b0, 1'b1, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL os_resume: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
   endtask

   task automatic test_load_sat;
      logic [N+2:0] tbl [4];
      tbl[0] = {5'd0,  1'b0, 1'b1, 1'b0};
      tbl[1] = {5'd1,  1'b0, 1'b1, 1'b0};
      tbl[2] = {5'd19, 1'b0, 1'b1, 1'b0};
      tbl[3] = {5'd0,  1'b1, 1'b1, 1'b0};
      apply_reset(1'b0);
      LoadVal = 5'd25;
      for (int i = 0; i < 4; i++) begin
         Load = (i == 2);
         tick;
         nchecks++;
         if (obs !== tbl[i]) begin
            nerrors++;
            $display("FAIL load_%0d: got {Q,R,B,D}=%b want %b", i, obs, tbl[i]);
         end
      end
      Load = 1'b0;
   endtask

   task automatic test_reset_mid;
      for (int v = 1; v <= 11; v++) begin
         if (v == 11) begin
            ModWr = 1'b1;
            ModIn = 5'd10;
         end
         tick;
      end
      ModWr = 1'b0;
      exp_v = {5'd11, 1'b0, 1'b1, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL mid_pre: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
      #2;
      Reset = 1'b1;
      #1;
      exp_v = {5'd0, 1'b0, 1'b0, 1'b0};
      nchecks++;
      if (obs !== exp_v) begin
         nerrors++;
         $display("FAIL mid_async: got {Q,R,B,D}=%b want %b", obs, exp_v);
      end
      tick;
      Reset = 1'b0;
      // Period must be 20 both times: the pending 10 was discarded.
      for (int c = 1; c <= 32; c++) begin
         tick;
         exp_v = {N'((c - 1) % 20), (c == 21), 1'b1, 1'b0};
         nchecks++;
         if (obs !== exp_v) begin
            nerrors++;
            $display("FAIL mid_post_c%0d: got {Q,R,B,D}=%b want %b", c, obs, exp_v);
         end
      end
   endtask

`ifdef MODK_CASCADE_EN
   task automatic test_cascade;
      logic [2*N-1:0] got, want;
      apply_reset(1'b0);
      for (int c = 1; c <= 17; c++) begin
         tick;
         got  = {q1, q2};
         want = {N'((c - 1) % 4), N'(((c - 1) / 4) % 4)};
         nchecks++;
         if (got !== want) begin
            nerrors++;
            $display("FAIL cascade_c%0d: got {q1,q2}=%b want %b", c, got, want);
         end
      end
      nchecks++;
      if (r2 !== 1'b1) begin
         nerrors++;
         $display("FAIL cascade_wrap: got r2=%b want 1", r2);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_continuous_up();
      test_count_down();
      test_modwr();
      test_oneshot();
      test_load_sat();
      test_reset_mid();
`ifdef MODK_CASCADE_EN
      test_cascade();
`endif
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule : tb_prog_modulo_counter
`default_nettype wire
